// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU port arbiter: LSU op encodings,
// the output-peripheral address window and the registered request record.
package lsu_pkg;

    // ld_op[2:0] access size, ld_op[3] sign-extends loads
    localparam logic [2:0] OP_B          = 3'b001;
    localparam logic [2:0] OP_H          = 3'b011;
    localparam logic [2:0] OP_W          = 3'b111;
    localparam int         OP_SIGNED_BIT = 3;

    // Output peripherals latch on any access, load or store
    localparam logic [31:0] PERIPH_LO_ADDR = 32'h0000_0800;
    localparam logic [31:0] PERIPH_HI_ADDR = 32'h0000_08A0;
    localparam logic [31:0] PERIPH_X_ADDR  = 32'h0000_0900;

    typedef enum logic {
        PORT_M0 = 1'b0,
        PORT_M1 = 1'b1
    } port_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  op;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic is_periph(input logic [31:0] addr);
        return ((addr >= PERIPH_LO_ADDR) && (addr <= PERIPH_HI_ADDR)) ||
               (addr == PERIPH_X_ADDR);
    endfunction

endpackage

// File: rtl/lsu_port_arbiter_if.sv
// One requester's view of the arbitrated LSU port: request, lock,
// grant handshake and load response.
interface lsu_port_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  op;
    logic [31:0] wdata;
    logic        lock;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, op, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, op, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/lsu_rr_arb2.sv
// Two-way round-robin arbiter with a lock that lets the current winner keep
// the port for back-to-back accesses. Grants are combinational; the
// round-robin pointer and lock owner are the only state.
module lsu_rr_arb2
    import lsu_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o,
    output port_e      owner_o
);

    port_e rr_q, rr_d;
    logic  lock_vld_q, lock_vld_d;
    port_e lock_own_q, lock_own_d;

    logic       hold;
    port_e      win;
    logic [1:0] gnt;

    // Pick the winner and compute next pointer / lock ownership
    always_comb begin
        hold       = lock_vld_q && lock_i[lock_own_q];
        gnt        = 2'b00;
        win        = rr_q;
        rr_d       = rr_q;
        lock_vld_d = 1'b0;
        lock_own_d = lock_own_q;
        if (hold) begin
            // Owner keeps the port; pointer frozen while the lock is held
            lock_vld_d    = 1'b1;
            win           = lock_own_q;
            gnt[win]      = req_i[win];
        end else begin
            // Ownership (if any) lapses this cycle; arbitrate normally
            case (req_i)
                2'b01:   win = PORT_M0;
                2'b10:   win = PORT_M1;
                default: win = rr_q;
            endcase
            if (|req_i) begin
                gnt[win] = 1'b1;
                rr_d     = (win == PORT_M0) ? PORT_M1 : PORT_M0;
                if (lock_i[win]) begin
                    lock_vld_d = 1'b1;
                    lock_own_d = win;
                end
            end
        end
    end

    assign gnt_o   = gnt;
    assign owner_o = win;

    // Pointer and lock-owner state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= port_e'(RR_INIT);
            lock_vld_q <= 1'b0;
            lock_own_q <= PORT_M0;
        end else begin
            rr_q       <= rr_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
        end
    end

endmodule

// File: rtl/lsu_port_arbiter.sv
// Shares the single LSU data port between the core MEM stage (m0) and the
// debug/boot loader (m1). A granted request is registered into an issue slot
// that drives the LSU for exactly one cycle; load data is registered and
// returned one cycle later. Loads loop the read data back onto st_data so
// that output peripherals, which latch on any access, rewrite their own value.
module lsu_port_arbiter
    import lsu_pkg::*;
#(
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000,
    parameter logic        RR_INIT   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    lsu_port_arbiter_if.slave    m0,
    lsu_port_arbiter_if.slave    m1,
    output logic [31:0]          lsu_addr_o,
    output logic [3:0]           lsu_ld_op_o,
    output logic [31:0]          lsu_st_data_o,
    output logic                 lsu_st_en_o,
    input  logic [31:0]          lsu_ld_data_i
);

    logic [1:0] req_vec;
    logic [1:0] lock_vec;
    logic [1:0] gnt_vec;
    port_e      win;
    lsu_req_t   req_in [2];

    assign req_vec  = {m1.req,  m0.req};
    assign lock_vec = {m1.lock, m0.lock};

    assign req_in[0].addr  = m0.addr;
    assign req_in[0].we    = m0.we;
    assign req_in[0].op    = m0.op;
    assign req_in[0].wdata = m0.wdata;
    assign req_in[1].addr  = m1.addr;
    assign req_in[1].we    = m1.we;
    assign req_in[1].op    = m1.op;
    assign req_in[1].wdata = m1.wdata;

    lsu_rr_arb2 #(
        .RR_INIT (RR_INIT)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_vec),
        .lock_i  (lock_vec),
        .gnt_o   (gnt_vec),
        .owner_o (win)
    );

    // Issue slot: one access in flight, drained every cycle
    logic     slot_vld_q, slot_vld_d;
    lsu_req_t slot_req_q, slot_req_d;
    port_e    slot_own_q, slot_own_d;

    // Capture the winner's request; hold the payload when nothing is granted
    always_comb begin
        slot_vld_d = |gnt_vec;
        slot_req_d = slot_req_q;
        slot_own_d = slot_own_q;
        if (|gnt_vec) begin
            slot_req_d = req_in[win];
            slot_own_d = win;
        end
    end

    // Issue slot registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_vld_q <= 1'b0;
            slot_req_q <= '0;
            slot_own_q <= PORT_M0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_req_q <= slot_req_d;
            slot_own_q <= slot_own_d;
        end
    end

    // Drive the LSU from the slot; an empty slot parks on a benign address
    always_comb begin
        lsu_addr_o    = IDLE_ADDR;
        lsu_ld_op_o   = 4'h0;
        lsu_st_en_o   = 1'b0;
        lsu_st_data_o = 32'h0;
        if (slot_vld_q) begin
            lsu_addr_o    = slot_req_q.addr;
            lsu_ld_op_o   = slot_req_q.op;
            lsu_st_en_o   = slot_req_q.we;
            lsu_st_data_o = slot_req_q.we ? slot_req_q.wdata : lsu_ld_data_i;
        end
    end

    // Per-port load response registers
    logic [1:0]  rsp_vld;
    logic [31:0] rsp_data [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic        rvalid_q, rvalid_d;
        logic [31:0] rdata_q, rdata_d;
        port_e       my_port;

        assign my_port = (gi == 0) ? PORT_M0 : PORT_M1;

        // Pulse rvalid for the slot owner's load; rdata holds between loads
        always_comb begin
            rvalid_d = slot_vld_q && !slot_req_q.we && (slot_own_q == my_port);
            rdata_d  = rvalid_d ? lsu_ld_data_i : rdata_q;
        end

        // Response registers
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_q <= 1'b0;
                rdata_q  <= 32'h0;
            end else begin
                rvalid_q <= rvalid_d;
                rdata_q  <= rdata_d;
            end
        end

        assign rsp_vld[gi]  = rvalid_q;
        assign rsp_data[gi] = rdata_q;
    end

    assign m0.gnt    = gnt_vec[0];
    assign m0.rvalid = rsp_vld[0];
    assign m0.rdata  = rsp_data[0];
    assign m1.gnt    = gnt_vec[1];
    assign m1.rvalid = rsp_vld[1];
    assign m1.rdata  = rsp_data[1];

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Directed bench for lsu_port_arbiter. Each stimulus cycle pushes the
// expected LSU issue (next cycle) and, for granted loads, the expected
// response (two cycles later); a monitor compares them as they appear.
// A small LSU model with memory and latch-on-any-access peripherals sits
// on the LSU side.
module tb_lsu_port_arbiter;

    localparam logic [31:0] IDLE = 32'h0000_0000;
    localparam logic [3:0]  OPW  = 4'b0111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_port_arbiter_if m0_if ();
    lsu_port_arbiter_if m1_if ();

    logic [31:0] lsu_addr, lsu_st_data, lsu_ld_data;
    logic [3:0]  lsu_ld_op;
    logic        lsu_st_en;

    lsu_port_arbiter #(
        .IDLE_ADDR (IDLE),
        .RR_INIT   (1'b0)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .m0            (m0_if),
        .m1            (m1_if),
        .lsu_addr_o    (lsu_addr),
        .lsu_ld_op_o   (lsu_ld_op),
        .lsu_st_data_o (lsu_st_data),
        .lsu_st_en_o   (lsu_st_en),
        .lsu_ld_data_i (lsu_ld_data)
    );

    // ---------------- LSU model ----------------
    logic [31:0] mem    [0:511];
    logic [31:0] periph [0:127];

    function automatic logic tb_periph(input logic [31:0] a);
        return ((a >= 32'h800) && (a <= 32'h8A0)) || (a == 32'h900);
    endfunction

    always_comb lsu_ld_data = tb_periph(lsu_addr) ? periph[lsu_addr[8:2]] : mem[lsu_addr[10:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) periph[i] <= 32'h0;
        end else if (tb_periph(lsu_addr)) begin
            periph[lsu_addr[8:2]] <= lsu_st_data;
        end else if (lsu_st_en) begin
            mem[lsu_addr[10:2]] <= lsu_st_data;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        st_en;
        logic [3:0]  op;
        logic [31:0] sdata;
    } iss_t;

    typedef struct {
        int          cyc;
        logic        port;
        logic [31:0] data;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    iss_t mon_it;
    rsp_t mon_rs;
    logic [1:0] mon_exp;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [3:0] op0 = OPW;
    logic [3:0] op1 = OPW;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: issue drive and load responses
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rvalid_in_reset", {30'b0, m1_if.rvalid, m0_if.rvalid}, 32'h0);
        end else begin
            if (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
                mon_it = iss_q.pop_front();
                chk("issue_cycle", cyc, mon_it.cyc);
                chk("lsu_addr", lsu_addr, mon_it.addr);
                chk("lsu_st_en", {31'b0, lsu_st_en}, {31'b0, mon_it.st_en});
                chk("lsu_ld_op", {28'b0, lsu_ld_op}, {28'b0, mon_it.op});
                chk("lsu_st_data", lsu_st_data, mon_it.sdata);
            end
            mon_exp = 2'b00;
            if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                mon_rs  = rsp_q.pop_front();
                mon_exp = mon_rs.port ? 2'b10 : 2'b01;
            end
            if (mon_exp != 2'b00 || m0_if.rvalid || m1_if.rvalid) begin
                chk("rvalid", {30'b0, m1_if.rvalid, m0_if.rvalid}, {30'b0, mon_exp});
                if (mon_exp != 2'b00) begin
                    chk("rdata", mon_rs.port ? m1_if.rdata : m0_if.rdata, mon_rs.data);
                    $display("rsp m%0d data=%h cycle=%0d", mon_rs.port, mon_rs.port ? m1_if.rdata : m0_if.rdata, cyc);
                end
            end
        end
    end

    // One arbitration cycle: drive both requesters, check grants, queue expectations
    task automatic step(input logic r0, input logic [31:0] a0, input logic we0, input logic [31:0] d0, input logic l0,
                        input logic r1, input logic [31:0] a1, input logic we1, input logic [31:0] d1, input logic l1,
                        input logic eg0, input logic eg1, input logic [31:0] eld);
        iss_t it;
        rsp_t rs;
        m0_if.req = r0; m0_if.addr = a0; m0_if.we = we0; m0_if.wdata = d0; m0_if.lock = l0; m0_if.op = op0;
        m1_if.req = r1; m1_if.addr = a1; m1_if.we = we1; m1_if.wdata = d1; m1_if.lock = l1; m1_if.op = op1;
        @(negedge clk);
        chk("m0_gnt", {31'b0, m0_if.gnt}, {31'b0, eg0});
        chk("m1_gnt", {31'b0, m1_if.gnt}, {31'b0, eg1});
        it.cyc = cyc + 1;
        it.addr = IDLE; it.st_en = 1'b0; it.op = 4'h0; it.sdata = 32'h0;
        if (eg0) begin
            it.addr = a0; it.st_en = we0; it.op = op0; it.sdata = we0 ? d0 : eld;
        end else if (eg1) begin
            it.addr = a1; it.st_en = we1; it.op = op1; it.sdata = we1 ? d1 : eld;
        end
        iss_q.push_back(it);
        if ((eg0 && !we0) || (eg1 && !we1)) begin
            rs.cyc = cyc + 2; rs.port = eg1; rs.data = eld;
            rsp_q.push_back(rs);
        end
        if (eg0 || eg1)
            $display("gnt m%0d addr=%h we=%0d cycle=%0d", eg1, it.addr, it.st_en, cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_if.req = 1'b0; m0_if.addr = 32'h0; m0_if.we = 1'b0; m0_if.wdata = 32'h0; m0_if.lock = 1'b0; m0_if.op = 4'h0;
        m1_if.req = 1'b0; m1_if.addr = 32'h0; m1_if.we = 1'b0; m1_if.wdata = 32'h0; m1_if.lock = 1'b0; m1_if.op = 4'h0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_m0_gnt"},   {31'b0, m0_if.gnt},    32'h0);
        chk({tag, "_m1_gnt"},   {31'b0, m1_if.gnt},    32'h0);
        chk({tag, "_m0_rdata"}, m0_if.rdata,           32'h0);
        chk({tag, "_m1_rdata"}, m1_if.rdata,           32'h0);
        chk({tag, "_addr"},     lsu_addr,              IDLE);
        chk({tag, "_st_en"},    {31'b0, lsu_st_en},    32'h0);
        chk({tag, "_ld_op"},    {28'b0, lsu_ld_op},    32'h0);
        chk({tag, "_st_data"},  lsu_st_data,           32'h0);
    endtask

    initial begin
        int nz;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle after reset: parked on IDLE_ADDR, peripherals untouched
        repeat (3) step(0,0,0,0,0, 0,0,0,0,0, 0,0, 0);
        nz = 0;
        for (int i = 0; i < 128; i++) if (periph[i] != 32'h0) nz++;
        chk("periph_idle", nz, 0);

        // Single requesters
        step(0,0,0,0,0,                1,32'h010,1,32'hDEADBEEF,0, 0,1, 0);
        step(1,32'h010,0,0,0,          0,0,0,0,0,                  1,0, 32'hDEADBEEF);
        step(0,0,0,0,0,                1,32'h014,1,32'h0BADF00D,0, 0,1, 0);

        // Both requesting: alternate m0, m1, m0, m1 (pointer back at m0)
        step(1,32'h010,0,0,0,          1,32'h010,0,0,0,            1,0, 32'hDEADBEEF);
        step(1,32'h030,1,32'h12345678,0, 1,32'h010,0,0,0,          0,1, 32'hDEADBEEF);
        step(1,32'h030,1,32'h12345678,0, 1,32'h030,0,0,0,          1,0, 0);
        step(1,32'h014,0,0,0,          1,32'h030,0,0,0,            0,1, 32'h12345678);
        step(1,32'h014,0,0,0,          0,0,0,0,0,                  1,0, 32'h0BADF00D);

        // m1 locks for two stores; m0 waits, then wins when lock drops
        step(1,32'h020,0,0,0,          1,32'h020,1,32'h11,1,       0,1, 0);
        step(1,32'h020,0,0,0,          1,32'h024,1,32'h22,1,       0,1, 0);
        step(1,32'h020,0,0,0,          0,0,0,0,0,                  1,0, 32'h11);
        step(1,32'h024,0,0,0,          1,32'h028,1,32'h33,0,       0,1, 0);
        step(1,32'h024,0,0,0,          0,0,0,0,0,                  1,0, 32'h22);

        // Peripheral: set LEDR, load it back, value must survive the load
        step(0,0,0,0,0,                1,32'h880,1,32'h5A,0,       0,1, 0);
        step(1,32'h880,0,0,0,          0,0,0,0,0,                  1,0, 32'h5A);
        // Unlisted op code forwarded unchanged
        op0 = 4'b0101;
        step(1,32'h010,0,0,0,          0,0,0,0,0,                  1,0, 32'hDEADBEEF);
        op0 = OPW;
        repeat (2) step(0,0,0,0,0, 0,0,0,0,0, 0,0, 0);
        chk("ledr_after_load", periph[32], 32'h5A);

        // Reset while an m0 load sits in the issue slot
        step(1,32'h010,0,0,0,          0,0,0,0,0,                  1,0, 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        iss_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        check_reset("mid");
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Pointer back at RR_INIT: m0 wins the tie
        step(1,32'h010,0,0,0,          1,32'h014,0,0,0,            1,0, 32'hDEADBEEF);
        step(0,0,0,0,0,                1,32'h014,0,0,0,            0,1, 32'h0BADF00D);
        repeat (2) step(0,0,0,0,0, 0,0,0,0,0, 0,0, 0);
        idle_inputs();
        @(negedge clk); #1;
        chk("scoreboard_drained", iss_q.size() + rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
